// File: rtl/lcd_hd44780_driver.sv
`default_nettype none
// ============================================================================
// Module  : lcd_hd44780_driver
// Brief   : Timed HD44780 write driver; runs power-up init, then one byte per
//           valid/ready handshake with setup / enable / hold / execute timing.
// Revision: 1.0
// ============================================================================
module lcd_hd44780_driver #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_CMD   = 1850,
  parameter int T_CLR   = 76000,
  parameter int T_PWRUP = 2000000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  output logic       init_done_o,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int c_MAX_T = max2(max2(max2(T_SETUP, T_EN), max2(T_HOLD, T_CMD)),
                                max2(max2(T_CLR, T_PWRUP), max2(T_INIT1, T_INIT2)));
  localparam int c_CNT_W = $clog2(c_MAX_T + 1);

  localparam logic [c_CNT_W-1:0] c_SETUP_M1 = c_CNT_W'(T_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_EN_M1    = c_CNT_W'(T_EN - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_M1  = c_CNT_W'(T_HOLD - 1);
  localparam logic [c_CNT_W-1:0] c_CMD_M1   = c_CNT_W'(T_CMD - 1);
  localparam logic [c_CNT_W-1:0] c_CLR_M1   = c_CNT_W'(T_CLR - 1);
  localparam logic [c_CNT_W-1:0] c_PWRUP_M1 = c_CNT_W'(T_PWRUP - 1);
  localparam logic [c_CNT_W-1:0] c_INIT1_M1 = c_CNT_W'(T_INIT1 - 1);
  localparam logic [c_CNT_W-1:0] c_INIT2_M1 = c_CNT_W'(T_INIT2 - 1);

  typedef enum logic [2:0] {
    S_PWRUP     = 3'd0,
    S_LOAD_INIT = 3'd1,
    S_IDLE      = 3'd2,
    S_SETUP     = 3'd3,
    S_PULSE     = 3'd4,
    S_HOLD      = 3'd5,
    S_EXEC      = 3'd6
  } state_t;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h38;
      3'd4:             init_byte = 8'h08;
      3'd5:             init_byte = 8'h01;
      3'd6:             init_byte = 8'h06;
      default:          init_byte = 8'h0C;
    endcase
  endfunction

  function automatic logic [c_CNT_W-1:0] init_wait_m1(input logic [2:0] idx);
    case (idx)
      3'd0:    init_wait_m1 = c_INIT1_M1;
      3'd1:    init_wait_m1 = c_INIT2_M1;
      3'd5:    init_wait_m1 = c_CLR_M1;
      default: init_wait_m1 = c_CMD_M1;
    endcase
  endfunction

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   r_wait_m1;
  logic [2:0]           r_idx;
  logic                 r_ready;
  logic                 r_init_done;
  logic [7:0]           r_data;
  logic                 r_rs;
  logic                 r_en;
  logic                 r_on;
  logic [c_CNT_W-1:0]   w_limit;
  logic                 w_hit;
  logic                 w_clr_cmd;

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_PWRUP: w_limit = c_PWRUP_M1;
      S_SETUP: w_limit = c_SETUP_M1;
      S_PULSE: w_limit = c_EN_M1;
      S_HOLD:  w_limit = c_HOLD_M1;
      S_EXEC:  w_limit = r_wait_m1;
      default: w_limit = '0;
    endcase
  end

  assign w_hit     = (r_cnt == w_limit);
  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
  assign w_clr_cmd = !wr_rs_i && ((wr_data_i == 8'h01) || (wr_data_i[7:1] == 7'b0000001));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_wait_m1   <= '0;
      r_idx       <= 3'd0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_on        <= 1'b0;
    end else begin
      r_on <= 1'b1;
      case (r_state)
        S_PWRUP: begin
          if (w_hit) begin
            r_cnt   <= '0;
            r_state <= S_LOAD_INIT;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_LOAD_INIT: begin
          r_rs      <= 1'b0;
          r_data    <= init_byte(r_idx);
          r_wait_m1 <= init_wait_m1(r_idx);
          r_cnt     <= '0;
          r_state   <= S_SETUP;
        end
        S_IDLE: begin
          if (wr_valid_i && r_ready) begin
            r_rs      <= wr_rs_i;
            r_data    <= wr_data_i;
            r_wait_m1 <= w_clr_cmd ? c_CLR_M1 : c_CMD_M1;
            r_ready   <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_hit) begin
            r_cnt   <= '0;
            r_en    <= 1'b1;
            r_state <= S_PULSE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (w_hit) begin
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (w_hit) begin
            r_cnt   <= '0;
            r_state <= S_EXEC;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (w_hit) begin
            r_cnt <= '0;
            if (!r_init_done && (r_idx != 3'd7)) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_LOAD_INIT;
            end else begin
              r_init_done <= 1'b1;
              r_ready     <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_PWRUP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign wr_ready_o  = r_ready;
  assign busy_o      = ~r_ready;
  assign init_done_o = r_init_done;
  assign lcd_data_o  = r_data;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = r_en;
  assign lcd_on_o    = r_on;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_hd44780_driver
// Brief   : Self-checking bench; pin activity is logged per cycle and compared
//           against a timing model derived from the driver's behaviour rules.
// Revision: 1.0
// ============================================================================
module tb_lcd_hd44780_driver;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;
  localparam int T_PWRUP = 50;
  localparam int T_INIT1 = 20;
  localparam int T_INIT2 = 8;
  localparam int c_N     = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  lcd_hd44780_driver #(
    .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_CMD(T_CMD),
    .T_CLR(T_CLR), .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_rs_i(wr_rs), .wr_data_i(wr_data), .init_done_o(init_done), .busy_o(busy),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
    .lcd_en_o(lcd_en), .lcd_on_o(lcd_on)
  );

  always #5 clk = ~clk;

  // Per-cycle pin log, sampled mid-cycle
  int         cyc = 0;
  logic       log_en [c_N];
  logic       log_rs [c_N];
  logic       log_rw [c_N];
  logic       log_on [c_N];
  logic       log_ready [c_N];
  logic       log_busy [c_N];
  logic       log_done [c_N];
  logic [7:0] log_data [c_N];

  always @(negedge clk) begin
    if (cyc < c_N) begin
      log_en[cyc]    = lcd_en;
      log_rs[cyc]    = lcd_rs;
      log_rw[cyc]    = lcd_rw;
      log_on[cyc]    = lcd_on;
      log_ready[cyc] = wr_ready;
      log_busy[cyc]  = busy;
      log_done[cyc]  = init_done;
      log_data[cyc]  = lcd_data;
    end
    cyc++;
  end

  typedef struct { int rise; logic rs; logic [7:0] data; } pulse_t;
  typedef struct { int acc; int free; } txn_t;

  pulse_t exp_q[$];
  txn_t   txn_q[$];
  int     m_free;
  int     done_log;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int model_wait(input logic r, input logic [7:0] d);
    return (!r && d >= 8'h01 && d <= 8'h03) ? T_CLR : T_CMD;
  endfunction

  // Expected init pulses when the first reset-free edge ends cycle l1-1
  task automatic model_init(input int l1);
    int rom_b [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    int rom_w [8] = '{T_INIT1, T_INIT2, T_CMD, T_CMD, T_CMD, T_CLR, T_CMD, T_CMD};
    int rise;
    rise = l1 + T_PWRUP + T_SETUP;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{rise, 1'b0, rom_b[i][7:0]});
      m_free = rise + T_EN + T_HOLD + rom_w[i];
      rise   = m_free + 1 + T_SETUP;
    end
    done_log = m_free;
  endtask

  task automatic xfer(input logic r, input logic [7:0] d, input bit junk);
    int acc, fr;
    acc = (cyc > m_free) ? cyc : m_free;
    fr  = acc + 1 + T_SETUP + T_EN + T_HOLD + model_wait(r, d);
    exp_q.push_back('{acc + 1 + T_SETUP, r, d});
    txn_q.push_back('{acc, fr});
    m_free = fr;
    wr_valid = 1'b1;
    while (cyc < acc) begin
      wr_rs   = junk ? 1'($urandom) : r;
      wr_data = junk ? 8'($urandom) : d;
      tick();
    end
    wr_rs   = r;
    wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    while (cyc <= m_free + 2) tick();
  endtask

  task automatic check_pulses(input int s, input int e);
    int rises[$];
    int widths[$];
    int w, bad;
    pulse_t p;
    for (int i = s + 1; i < e; i++) begin
      if (log_en[i] && !log_en[i-1]) begin
        w = 0;
        while (i + w < e && log_en[i+w]) w++;
        rises.push_back(i);
        widths.push_back(w);
      end
    end
    chk("pulse_count", rises.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rises.size(); k++) begin
      p = exp_q[k];
      chk($sformatf("pulse_rise[%0d]", k), rises[k], p.rise);
      chk($sformatf("pulse_width[%0d]", k), widths[k], T_EN);
      bad = 0;
      for (int j = p.rise - T_SETUP; j < p.rise + T_EN + T_HOLD; j++)
        if (log_rs[j] !== p.rs || log_data[j] !== p.data) bad++;
      chk($sformatf("pulse_rs_data_%02h[%0d]", p.data, k), bad, 0);
    end
    exp_q.delete();
  endtask

  task automatic check_txns();
    foreach (txn_q[k]) begin
      chk($sformatf("ready_drop[%0d]", k), log_ready[txn_q[k].acc + 1], 1'b0);
      chk($sformatf("ready_late[%0d]", k), log_ready[txn_q[k].free - 1], 1'b0);
      chk($sformatf("ready_back[%0d]", k), log_ready[txn_q[k].free], 1'b1);
      chk($sformatf("busy_back[%0d]", k), log_busy[txn_q[k].free], 1'b0);
    end
    txn_q.delete();
  endtask

  task automatic check_init(input int l1);
    chk("on_before_release", log_on[l1 - 1], 1'b0);
    chk("on_after_release", log_on[l1], 1'b1);
    chk("init_done_early", log_done[done_log - 1], 1'b0);
    chk("init_ready_early", log_ready[done_log - 1], 1'b0);
    chk("init_done_rise", log_done[done_log], 1'b1);
    chk("init_ready_rise", log_ready[done_log], 1'b1);
  endtask

  initial begin
    int l1, p_rst, win, q, acc, rw_bad;
    logic [7:0] d;
    logic r;

    // Reset and power-up init
    repeat (3) tick();
    p_rst = cyc;
    tick();
    rst = 1'b0;
    l1 = cyc + 1;
    model_init(l1);
    drain();
    chk("rst_en", log_en[p_rst], 1'b0);
    chk("rst_on", log_on[p_rst], 1'b0);
    chk("rst_data", log_data[p_rst], 8'h00);
    chk("rst_rs", log_rs[p_rst], 1'b0);
    chk("rst_ready", log_ready[p_rst], 1'b0);
    chk("rst_busy", log_busy[p_rst], 1'b1);
    chk("rst_done", log_done[p_rst], 1'b0);
    check_init(l1);
    check_pulses(l1, cyc);
    win = cyc;

    // Data write, clear/home waits, plain command
    xfer(1'b1, 8'h41, 1'b0);
    xfer(1'b0, 8'h01, 1'b0);
    xfer(1'b0, 8'h02, 1'b0);
    xfer(1'b0, 8'h80, 1'b0);
    chk("wait_clear", txn_q[1].free - txn_q[1].acc, 39);
    chk("wait_home", txn_q[2].free - txn_q[2].acc, 39);
    chk("wait_cmd", txn_q[3].free - txn_q[3].acc, 19);
    chk("wait_data", txn_q[0].free - txn_q[0].acc, 19);
    drain();
    check_pulses(win, cyc);
    check_txns();
    win = cyc;

    // Request held while busy with data churning, then back-to-back bytes
    repeat (3) tick();
    xfer(1'b1, 8'h20, 1'b0);
    xfer(1'b1, 8'h55, 1'b1);
    xfer(1'b1, 8'h48, 1'b0);
    xfer(1'b1, 8'h49, 1'b0);
    xfer(1'b1, 8'h21, 1'b0);
    chk("b2b_gap0", txn_q[3].acc - txn_q[2].acc, 19);
    chk("b2b_gap1", txn_q[4].acc - txn_q[3].acc, 19);
    drain();
    check_pulses(win, cyc);
    check_txns();
    win = cyc;

    // Randomized traffic
    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      repeat ($urandom_range(0, 25)) tick();
      xfer(r, d, 1'($urandom));
    end
    drain();
    check_pulses(win, cyc);
    check_txns();

    // Reset in the middle of an enable pulse
    acc = (cyc > m_free) ? cyc : m_free;
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h77;
    while (cyc < acc + 1) tick();
    wr_valid = 1'b0;
    while (cyc < acc + 2 + T_SETUP) tick();
    rst = 1'b1;
    q = cyc;
    repeat (3) tick();
    chk("midrst_en_before", log_en[q], 1'b1);
    chk("midrst_en", log_en[q + 1], 1'b0);
    chk("midrst_on", log_on[q + 1], 1'b0);
    chk("midrst_ready", log_ready[q + 1], 1'b0);
    chk("midrst_done", log_done[q + 1], 1'b0);
    rst = 1'b0;
    l1 = cyc + 1;
    model_init(l1);
    drain();
    check_init(l1);
    check_pulses(q + 1, cyc);

    rw_bad = 0;
    for (int i = 0; i < cyc && i < c_N; i++) if (log_rw[i] !== 1'b0) rw_bad++;
    chk("rw_always_low", rw_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_hd44780_driver.md
Name: lcd_hd44780_driver

Overview:
- Timed driver for the DE2 16x2 character LCD (HD44780-compatible) on the LCD_DATA/RS/RW/EN/ON pins.
- Software no longer bit-bangs the pins: the processor I/O side pushes one command or data byte per valid/ready handshake.
- The block runs the power-up init sequence itself, then generates setup, enable-pulse, hold and execution-wait timing for every byte.
- It sits between the processor's LCD output register and the board pins, in the top-level wrapper.

Parameters:
- T_SETUP, 2: cycles that RS/DATA are stable before EN rises (40 ns at 50 MHz).
- T_EN, 12: cycles EN is held high (240 ns).
- T_HOLD, 2: cycles RS/DATA stay stable after EN falls.
- T_CMD, 1850: execution wait for normal commands and data writes (37 us).
- T_CLR, 76000: execution wait for clear/home commands (1.52 ms).
- T_PWRUP, 2000000: wait after reset before the first init byte (40 ms).
- T_INIT1, 205000: wait after the 1st function-set byte (4.1 ms).
- T_INIT2, 5000: wait after the 2nd function-set byte (100 us).

Ports:
- clk_i, in, 1: system clock (CLOCK_50).
- rst_i, in, 1: reset.
- wr_valid_i, in, 1: byte request from the processor side.
- wr_ready_o, out, 1: driver can accept a byte.
- wr_rs_i, in, 1: 0 = command, 1 = character data.
- wr_data_i, in, 8: byte to write.
- init_done_o, out, 1: init sequence complete.
- busy_o, out, 1: equals ~wr_ready_o.
- lcd_data_o, out, 8: LCD_DATA.
- lcd_rs_o, out, 1: LCD_RS.
- lcd_rw_o, out, 1: LCD_RW. Always 0; the driver is write-only.
- lcd_en_o, out, 1: LCD_EN.
- lcd_on_o, out, 1: LCD_ON.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - lcd_data_o = 0x00, lcd_rs_o = 0, lcd_rw_o = 0, lcd_en_o = 0, lcd_on_o = 0.
  - wr_ready_o = 0, busy_o = 1, init_done_o = 0.
  - FSM = PWRUP, all counters = 0, init index = 0.
- lcd_on_o becomes 1 on the first cycle after reset is released and stays 1.
- A reset asserted mid-operation (any state) takes effect at the next edge: EN drops immediately and the full init sequence reruns.
- All outputs are registered; no combinational path from inputs to pins.
- FSM states and transitions:
  - PWRUP: count T_PWRUP cycles, then go to LOAD_INIT.
  - LOAD_INIT: latch init ROM[idx] (RS = 0) with its wait value, then go to SETUP.
  - IDLE: wr_ready_o = 1. On wr_valid_i & wr_ready_o, latch wr_rs_i/wr_data_i and go to SETUP. wr_ready_o falls on the next cycle.
  - SETUP: lcd_rs_o/lcd_data_o driven from the latch; EN = 0. Lasts T_SETUP cycles, then go to PULSE.
  - PULSE: EN = 1 for T_EN cycles, then go to HOLD.
  - HOLD: EN = 0, RS/DATA unchanged, T_HOLD cycles, then go to EXEC.
  - EXEC: count the selected wait. On completion:
    - during init: increment idx; after the last entry set init_done_o = 1 and go to IDLE, otherwise go to LOAD_INIT;
    - after a user byte: go to IDLE.
- Init ROM, 8 entries, byte/wait:
  - 0x30 / T_INIT1
  - 0x30 / T_INIT2
  - 0x30 / T_CMD
  - 0x38 / T_CMD
  - 0x08 / T_CMD
  - 0x01 / T_CLR
  - 0x06 / T_CMD
  - 0x0C / T_CMD
- Wait selection for user bytes:
  - T_CLR if RS = 0 and (data == 0x01 or data[7:1] == 7'b0000001);
  - otherwise T_CMD, including all RS = 1 writes.
- Latency for a byte accepted at edge k:
  - RS/DATA valid from cycle k+1.
  - EN high in cycles k+1+T_SETUP through k+T_SETUP+T_EN.
  - wr_ready_o = 1 again at cycle k+1+T_SETUP+T_EN+T_HOLD+T_wait.
- lcd_rs_o/lcd_data_o change only when leaving IDLE or LOAD_INIT; they keep their last value while in IDLE.
- Handshake rules:
  - wr_valid_i asserted while wr_ready_o = 0 is ignored, with no queueing. The requester must hold valid until accepted.
  - wr_data_i changes while not ready have no effect.
  - Back-to-back: if valid stays high in IDLE, the next byte is accepted on the first IDLE cycle. There is no idle bubble beyond that one cycle.
- Counters are wide enough for the largest parameter (≥ 21 bits at defaults) and compare to PARAM-1. Wrap-around never occurs.

Test Plan (sim parameters: T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD=10, T_CLR=30, T_PWRUP=50, T_INIT1=20, T_INIT2=8):
- Init sequence:
  - Stimulus: release reset, wr_valid_i = 0.
  - Expect: lcd_on_o = 1 next cycle.
  - Expect: exactly 8 EN pulses, each 4 cycles wide, carrying bytes 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C with RS = 0, RW = 0.
  - Expect: the first EN rises at cycle 50+1+2; gaps between EN falls match the waits; init_done_o rises after the 0x0C wait.
- Data write timing:
  - Stimulus: after init, pulse valid with rs = 1, data = 0x41.
  - Expect: wr_ready_o low the next cycle; RS = 1 and DATA = 0x41 stable for 2 cycles before EN and 2 cycles after EN.
  - Expect: EN high for 4 cycles; ready returns 1+2+4+2+10 = 19 cycles after acceptance.
- Clear wait:
  - Stimulus: write rs = 0, data = 0x01, then rs = 0, data = 0x02.
  - Expect: ready returns at 39 cycles for each.
  - Stimulus: write rs = 0, data = 0x80.
  - Expect: ready returns at 19 cycles.
- Ignored request:
  - Stimulus: while busy, change data to 0x55 with valid held.
  - Expect: no extra EN pulse during the current transfer; 0x55 is accepted on the first IDLE cycle and its EN pulse follows.
- Back-to-back:
  - Stimulus: hold valid high for 3 bytes 0x48, 0x49, 0x21.
  - Expect: three pulses in order, with exactly 19 cycles between acceptances.
- Mid-operation reset:
  - Stimulus: assert rst_i during PULSE.
  - Expect: the next edge shows EN = 0, lcd_on_o = 0, ready = 0, init_done_o = 0.
  - Expect: after release, the full 8-byte init sequence reruns.
